// File: rtl/slice_field_pkg.sv
// slice_field_pkg
// Shared types and helpers for the slice_field_bank block.
//   state_t     : bulk-clear FSM state encoding
//   FIELD_INIT  : reset / clear value of every channel register
//   clamp_len   : limits a requested field length to the maximum field width
package slice_field_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Wide enough for any practical DATA_W; users take the low DATA_W bits.
    localparam logic [63:0] FIELD_INIT = '0;

    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/slice_field_merge.sv
// slice_field_merge
// Combinational bit-field merge: inserts the low len bits of data into
// old_val starting at bit lsb. Bits that would land above DATA_W-1 are dropped
// and flagged on clip.
// Ports:
//   old_val [DATA_W]  : current register value
//   lsb     [LSB_W]   : field LSB position
//   len     [LEN_W]   : requested field length (clamped to FIELD_W)
//   data    [FIELD_W] : field value, right-aligned
//   new_val [DATA_W]  : merged register value
//   clip    [1]       : field extended past the top of the register
module slice_field_merge
    import slice_field_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int FIELD_W = 7,
    parameter int LSB_W   = $clog2(DATA_W),
    parameter int LEN_W   = $clog2(FIELD_W + 1)
) (
    input  logic [DATA_W-1:0]  old_val,
    input  logic [LSB_W-1:0]   lsb,
    input  logic [LEN_W-1:0]   len,
    input  logic [FIELD_W-1:0] data,
    output logic [DATA_W-1:0]  new_val,
    output logic               clip
);

    // Shifting at DATA_W+FIELD_W bits keeps out-of-range field bits from
    // wrapping back into the low end before truncation.
    localparam int WIDE_W = DATA_W + FIELD_W;

    logic [WIDE_W-1:0] field_mask;
    logic [WIDE_W-1:0] field_data;
    logic [DATA_W-1:0] mask_lo;
    logic [DATA_W-1:0] data_lo;
    int                eff_len;

    always_comb begin
        eff_len    = clamp_len(int'(len), FIELD_W);
        field_mask = (WIDE_W'(1) << eff_len) - WIDE_W'(1);
        field_data = WIDE_W'(data) & field_mask;
        mask_lo    = DATA_W'(field_mask << lsb);
        data_lo    = DATA_W'(field_data << lsb);
        new_val    = (old_val & ~mask_lo) | data_lo;
        clip       = (int'(lsb) + eff_len) > DATA_W;
    end

endmodule

// File: rtl/slice_field_bank.sv
// slice_field_bank
// Bank of CH independent DATA_W-bit registers updated by partial bit-field
// writes, read through a registered port extended to OUT_W bits.
// Optional feature macro: SLICE_FIELD_FWD_EN -- forwards a same-cycle accepted
// write to the read channel into rd_data (read-after-write); default is
// read-before-write.
// Ports:
//   clock_0   : clock, rising edge
//   reset_n   : synchronous active-low reset
//   clr       : pulse, starts a bulk clear walk over all channels
//   wr_valid  : write request;  wr_ready : write accepted when both high
//   wr_ch/wr_lsb/wr_len/wr_data : write target channel and field
//   rd_ch     : read channel;   rd_data  : registered extended value
//   clip      : sticky per-channel clip flags
//   busy      : bulk clear in progress
//
// state   | meaning
// S_IDLE  | accepting writes; clr starts a walk
// S_CLEAR | zeroing channel clr_idx each cycle, ascending; writes blocked
module slice_field_bank
    import slice_field_pkg::*;
#(
    parameter int CH      = 4,
    parameter int DATA_W  = 14,
    parameter int FIELD_W = 7,
    parameter int OUT_W   = 17,
    parameter int SIGNED  = 0
) (
    input  logic                           clock_0,
    input  logic                           reset_n,
    input  logic                           clr,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [$clog2(CH)-1:0]          wr_ch,
    input  logic [$clog2(DATA_W)-1:0]      wr_lsb,
    input  logic [$clog2(FIELD_W+1)-1:0]   wr_len,
    input  logic [FIELD_W-1:0]             wr_data,
    input  logic [$clog2(CH)-1:0]          rd_ch,
    output logic [OUT_W-1:0]               rd_data,
    output logic [CH-1:0]                  clip,
    output logic                           busy
);

    localparam int CH_W = $clog2(CH);

    state_t            state;
    logic [CH_W-1:0]   clr_idx;
    logic [DATA_W-1:0] regs [CH];
    logic [CH-1:0]     clip_q;
    logic [OUT_W-1:0]  rd_q;

    logic              wr_ch_ok;
    logic              rd_ch_ok;
    logic              wr_fire;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] merged;
    logic              merge_clip;
    logic [DATA_W-1:0] rd_src;
    logic [OUT_W-1:0]  rd_next;

    assign wr_ready = (state == S_IDLE) && !clr;
    assign busy     = (state == S_CLEAR);
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_data  = rd_q;
    assign clip     = clip_q;

    always_comb begin
        wr_ch_ok = int'(wr_ch) < CH;
        rd_ch_ok = int'(rd_ch) < CH;
        wr_old   = wr_ch_ok ? regs[wr_ch] : '0;
    end

    slice_field_merge #(
        .DATA_W  (DATA_W),
        .FIELD_W (FIELD_W)
    ) u_merge (
        .old_val (wr_old),
        .lsb     (wr_lsb),
        .len     (wr_len),
        .data    (wr_data),
        .new_val (merged),
        .clip    (merge_clip)
    );

    always_comb begin
        rd_src = rd_ch_ok ? regs[rd_ch] : '0;
`ifdef SLICE_FIELD_FWD_EN
        // The merge output for the write channel is exactly the post-write
        // value, so it doubles as the forwarding source.
        if (wr_fire && wr_ch_ok && (wr_ch == rd_ch)) begin
            rd_src = merged;
        end
`endif
        if (SIGNED != 0) begin
            rd_next = OUT_W'($signed(rd_src));
        end else begin
            rd_next = OUT_W'(rd_src);
        end
    end

    always_ff @(posedge clock_0) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            clr_idx <= '0;
            clip_q  <= '0;
            rd_q    <= '0;
            for (int i = 0; i < CH; i++) begin
                regs[i] <= FIELD_INIT[DATA_W-1:0];
            end
        end else begin
            rd_q <= rd_next;
            case (state)
                S_IDLE: begin
                    if (clr) begin
                        state   <= S_CLEAR;
                        clr_idx <= '0;
                    end else if (wr_fire && wr_ch_ok) begin
                        regs[wr_ch] <= merged;
                        if (merge_clip) begin
                            clip_q[wr_ch] <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    regs[clr_idx]   <= FIELD_INIT[DATA_W-1:0];
                    clip_q[clr_idx] <= 1'b0;
                    if (clr_idx == CH_W'(CH - 1)) begin
                        state   <= S_IDLE;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + CH_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
